uart_bit_rx: RTL and testbench
==============================

Name: uart_bit_rx

Overview:
- Serial front end that feeds the 8-bit shift register stage. It oversamples the asynchronous serial input (MIDI/UART framing: 1 start, DATA_BITS data LSB-first, 1 stop) and recovers the data bits.
- Per data bit it emits a one-cycle strobe, which drives the shift register's enable and data inputs.
- Per frame it emits a start pulse, used to clear the shift register, and a done or error pulse, used by the downstream byte consumer.

Parameters:
- CLKS_PER_BIT, 1600, system clocks per serial bit (50 MHz / 31250 baud); legal values are 4 or more.
- DATA_BITS, 8, data bits per frame; legal range 1 to 8.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- bit_data  output  1  recovered data bit; valid only while bit_valid is high.
- bit_valid  output  1  one-cycle strobe, one per data bit; connects to the shift register's enable.
- frame_start  output  1  one-cycle pulse when the start bit is confirmed.
- frame_done  output  1  one-cycle pulse when the stop bit is sampled high.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE; counters cleared.
  - rx synchroniser flops and rx_prev set to 1.
  - All outputs 0.
  - Reset mid-frame abandons the frame: no done/err pulse is issued.
- rx passes through a 2-flop synchroniser giving rx_s; rx_prev is rx_s delayed by one cycle.
- Start detection is a falling edge only: rx_prev=1 and rx_s=0. A line held low does not retrigger.
- IDLE:
  - On a falling edge, go to START and clear cnt.
- START:
  - cnt increments each cycle.
  - When cnt==CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
  - rx_s=0: go to DATA, clear cnt and bit index, pulse frame_start in that same cycle.
  - rx_s=1 (glitch): return to IDLE; no pulses.
- DATA:
  - When cnt==CLKS_PER_BIT-1: register bit_data=rx_s, pulse bit_valid for one cycle, clear cnt, increment idx.
  - When the sampled bit is bit DATA_BITS-1, go to STOP.
  - Otherwise cnt increments.
  - Bits are emitted LSB first, so the first bit_valid corresponds to bit 0 of the byte.
- STOP:
  - When cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: pulse frame_done. rx_s=0: pulse frame_err.
  - Return to IDLE in the same cycle.
  - After an error, a new frame requires rx high followed by a new falling edge.
- Sampling point: every bit is sampled at the nominal bit centre, one half-bit after the detected edge plus whole-bit multiples.
- Pulse exclusivity: bit_valid, frame_start, frame_done and frame_err are never high in the same cycle. Each is high for exactly one cycle per event.
- bit_data holds its last value between strobes.
- Back-to-back frames:
  - A falling edge that arrives in the cycle STOP returns to IDLE is not lost: IDLE evaluates the edge on the following cycle using rx_prev/rx_s.
  - The start is then detected within 1 cycle of its true position.
- Widths:
  - cnt is $clog2(CLKS_PER_BIT) bits.
  - idx is 3 bits and wraps harmlessly; it is cleared at each frame_start.
- Latency: rx edge to internal detection is 3 clk (2 synchroniser + edge register). All sample points are offset by this constant.

Decomposition:
- Shared package uart_pkg holds:
  - state enum IDLE/START/DATA/STOP (2 bits);
  - default constants CLKS_PER_BIT_MIDI=1600 and DATA_BITS_DEFAULT=8.
- One natural sub-module, sync2: a 2-flop synchroniser with a reset value parameter (here 1).
- The FSM and counters stay in uart_bit_rx.

Test Plan (sim with CLKS_PER_BIT=16, bit period 16 clk):
- Send byte 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1):
  - frame_start once;
  - 8 bit_valid pulses 16 clk apart with bit_data 1,0,1,0,0,1,0,1;
  - then frame_done once;
  - the shift register fed from these outputs holds 0xA5.
- rx low glitch of 5 clk while IDLE: no frame_start, busy returns to 0, no bit_valid.
- Byte 0x3C with stop bit 0: 8 bit pulses giving bits 0,0,1,1,1,1,0,0, then frame_err and no frame_done. Hold rx low 40 clk: no new frame_start until rx goes high and falls again.
- Two frames back-to-back, 0x01 then 0xFF, with no idle gap: two frame_start, 16 bit_valid, two frame_done; second frame bits all 1.
- Assert reset for 1 clk during the 4th data bit: outputs 0, busy=0, no frame_done/err. The next full frame 0x5A decodes correctly.
- Reset held high with rx toggling: all outputs stay 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART bit receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int CLKS_PER_BIT_MIDI = 1600;
    localparam int DATA_BITS_DEFAULT = 8;

endpackage

// File: rtl/uart_bit_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the input; both flops take the idle level on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_bit_rx.sv
// Oversampling UART receiver front end: recovers data bits LSB first and
// emits one-cycle strobes per bit plus frame start/done/error pulses.
module uart_bit_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_MIDI,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic bit_data,
    output logic bit_valid,
    output logic frame_start,
    output logic frame_done,
    output logic frame_err,
    output logic busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic             rx_s, rx_prev;
    logic             bit_data_n, bit_valid_n;
    logic             frame_start_n, frame_done_n, frame_err_n;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != IDLE);

    // State, counters, edge register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            rx_prev     <= 1'b1;
            bit_data    <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            rx_prev     <= rx_s;
            bit_data    <= bit_data_n;
            bit_valid   <= bit_valid_n;
            frame_start <= frame_start_n;
            frame_done  <= frame_done_n;
            frame_err   <= frame_err_n;
        end
    end

    // Next-state logic: half-bit confirm of the start bit, then one
    // sample per whole bit period so every sample lands mid-bit.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        idx_n         = idx;
        bit_data_n    = bit_data;
        bit_valid_n   = 1'b0;
        frame_start_n = 1'b0;
        frame_done_n  = 1'b0;
        frame_err_n   = 1'b0;
        case (state)
            IDLE: begin
                // Edge-only detection: a line stuck low never retriggers.
                if (rx_prev && !rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    if (!rx_s) begin
                        state_n       = DATA;
                        cnt_n         = '0;
                        idx_n         = '0;
                        frame_start_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    bit_data_n  = rx_s;
                    bit_valid_n = 1'b1;
                    cnt_n       = '0;
                    idx_n       = idx + 3'd1;
                    if (idx == IDX_LAST) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    frame_done_n = rx_s;
                    frame_err_n  = !rx_s;
                    cnt_n        = '0;
                    state_n      = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_bit_rx.sv
// Testbench for uart_bit_rx with a 16-clock bit period.
module tb_uart_bit_rx;

    localparam int CPB     = 16;
    localparam int K_START = 0;
    localparam int K_BIT   = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERR   = 3;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic bit_data, bit_valid, frame_start, frame_done, frame_err, busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int overlap_cnt = 0;
    logic [7:0] shreg = 8'h00;

    ev_t evq[$];
    ev_t expq[$];
    int  fall_q[$];

    uart_bit_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .bit_data    (bit_data),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe DUT outputs away from the active edge and log events.
    always @(negedge clk) begin
        int n;
        ev_t e;
        n = int'(bit_valid) + int'(frame_start) + int'(frame_done) + int'(frame_err);
        if (n > 1) overlap_cnt++;
        e.cyc = cyc;
        e.val = 0;
        if (frame_start) begin e.kind = K_START; evq.push_back(e); end
        if (bit_valid) begin
            e.kind = K_BIT; e.val = int'(bit_data); evq.push_back(e);
            shreg = {bit_data, shreg[7:1]};
        end
        if (frame_done) begin e.kind = K_DONE; e.val = 0; evq.push_back(e); end
        if (frame_err)  begin e.kind = K_ERR;  e.val = 0; evq.push_back(e); end
    end

    // Reference model: the event sequence a well-formed frame must produce.
    function automatic void model_frame(input logic [7:0] b, input bit ok);
        ev_t e;
        e.cyc = 0;
        e.kind = K_START; e.val = 0; expq.push_back(e);
        for (int i = 0; i < 8; i++) begin
            e.kind = K_BIT; e.val = int'(b[i]); expq.push_back(e);
        end
        e.kind = ok ? K_DONE : K_ERR; e.val = 0; expq.push_back(e);
    endfunction

    task automatic clear_logs();
        evq.delete();
        expq.delete();
        fall_q.delete();
    endtask

    // Drive one frame starting at the current negedge; rx is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input bit ok);
        rx = 1'b0;
        fall_q.push_back(cyc);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = ok;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bit_data !== 1'b0)    begin bad++; $display("FAIL rst_bit_data: got %b want 0", bit_data); end
        total++; if (bit_valid !== 1'b0)   begin bad++; $display("FAIL rst_bit_valid: got %b want 0", bit_valid); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
        total++; if (frame_done !== 1'b0)  begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        total++; if (frame_err !== 1'b0)   begin bad++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_byte_a5();
        int spc_err;
        int lat;
        clear_logs();
        model_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (evq.size() !== expq.size()) begin bad++; $display("FAIL a5_events: got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
            total++;
            if (evq[i].kind * 2 + evq[i].val !== expq[i].kind * 2 + expq[i].val) begin
                bad++; $display("FAIL a5_ev[%0d]: got kind=%0d val=%0d want kind=%0d val=%0d", i, evq[i].kind, evq[i].val, expq[i].kind, expq[i].val);
            end
        end
        spc_err = 0;
        for (int i = 1; i < evq.size(); i++)
            if (evq[i].kind != K_START && evq[i].cyc - evq[i-1].cyc != CPB) spc_err++;
        total++; if (spc_err !== 0) begin bad++; $display("FAIL a5_spacing: got %0d bad gaps want 0", spc_err); end
        lat = (evq.size() > 0 && fall_q.size() > 0) ? evq[0].cyc - fall_q[0] : -1;
        total++; if (lat < CPB / 2 || lat > CPB / 2 + 4) begin bad++; $display("FAIL a5_start_latency: got %0d want %0d..%0d", lat, CPB / 2, CPB / 2 + 4); end
        total++; if (shreg !== 8'hA5) begin bad++; $display("FAIL a5_shreg: got %h want a5", shreg); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL a5_busy: got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        int saw_busy;
        clear_logs();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        saw_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) saw_busy = 1;
        end
        total++; if (evq.size() !== 0) begin bad++; $display("FAIL glitch_events: got %0d want 0", evq.size()); end
        total++; if (saw_busy !== 1) begin bad++; $display("FAIL glitch_busy_seen: got %0d want 1", saw_busy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
    endtask

    task automatic test_stop_err();
        int n_after;
        clear_logs();
        model_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        total++; if (evq.size() !== expq.size()) begin bad++; $display("FAIL err_events: got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
            total++;
            if (evq[i].kind * 2 + evq[i].val !== expq[i].kind * 2 + expq[i].val) begin
                bad++; $display("FAIL err_ev[%0d]: got kind=%0d val=%0d want kind=%0d val=%0d", i, evq[i].kind, evq[i].val, expq[i].kind, expq[i].val);
            end
        end
        total++; if (shreg !== 8'h3C) begin bad++; $display("FAIL err_shreg: got %h want 3c", shreg); end
        n_after = evq.size();
        rx = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (evq.size() !== n_after) begin bad++; $display("FAIL err_no_retrigger: got %0d events want %0d", evq.size(), n_after); end
        clear_logs();
        send_frame(8'h96, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (evq.size() !== 10) begin bad++; $display("FAIL err_recover_events: got %0d want 10", evq.size()); end
        total++; if (shreg !== 8'h96) begin bad++; $display("FAIL err_recover_shreg: got %h want 96", shreg); end
    endtask

    task automatic test_back_to_back();
        int spc_err;
        clear_logs();
        model_frame(8'h01, 1'b1);
        model_frame(8'hFF, 1'b1);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        total++; if (evq.size() !== expq.size()) begin bad++; $display("FAIL b2b_events: got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
            total++;
            if (evq[i].kind * 2 + evq[i].val !== expq[i].kind * 2 + expq[i].val) begin
                bad++; $display("FAIL b2b_ev[%0d]: got kind=%0d val=%0d want kind=%0d val=%0d", i, evq[i].kind, evq[i].val, expq[i].kind, expq[i].val);
            end
        end
        spc_err = 0;
        for (int i = 1; i < evq.size(); i++)
            if (evq[i].kind != K_START && evq[i].cyc - evq[i-1].cyc != CPB) spc_err++;
        total++; if (spc_err !== 0) begin bad++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", spc_err); end
        total++; if (shreg !== 8'hFF) begin bad++; $display("FAIL b2b_shreg: got %h want ff", shreg); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int n_end;
        b = 8'h5A;
        clear_logs();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[3];
        repeat (4) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        total++; if ({bit_data, bit_valid, frame_start, frame_done, frame_err} !== 5'b0)
            begin bad++; $display("FAIL midrst_outputs: got %b want 00000", {bit_data, bit_valid, frame_start, frame_done, frame_err}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (40) @(negedge clk);
        n_end = 0;
        foreach (evq[i]) if (evq[i].kind == K_DONE || evq[i].kind == K_ERR) n_end++;
        total++; if (n_end !== 0) begin bad++; $display("FAIL midrst_no_end: got %0d want 0", n_end); end
        total++; if (evq.size() !== 4) begin bad++; $display("FAIL midrst_partial: got %0d events want 4", evq.size()); end
        clear_logs();
        model_frame(b, 1'b1);
        send_frame(b, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (evq.size() !== expq.size()) begin bad++; $display("FAIL midrst_next_events: got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
            total++;
            if (evq[i].kind * 2 + evq[i].val !== expq[i].kind * 2 + expq[i].val) begin
                bad++; $display("FAIL midrst_ev[%0d]: got kind=%0d val=%0d want kind=%0d val=%0d", i, evq[i].kind, evq[i].val, expq[i].kind, expq[i].val);
            end
        end
        total++; if (shreg !== 8'h5A) begin bad++; $display("FAIL midrst_shreg: got %h want 5a", shreg); end
    endtask

    task automatic test_reset_held();
        int errs;
        clear_logs();
        reset = 1'b1;
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            rx = 1'($urandom_range(0, 1));
            @(negedge clk);
            if ({bit_data, bit_valid, frame_start, frame_done, frame_err, busy} !== 6'b0) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL held_rst_outputs: got %0d nonzero cycles want 0", errs); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (evq.size() !== 0) begin bad++; $display("FAIL held_rst_events: got %0d want 0", evq.size()); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit ok;
        int spc_err, lat_err, k;
        clear_logs();
        b = 8'h00;
        for (int f = 0; f < 8; f++) begin
            b = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            model_frame(b, ok);
            send_frame(b, ok);
            rx = 1'b1;
            repeat (ok ? $urandom_range(0, 10) : $urandom_range(4, 10)) @(negedge clk);
        end
        rx = 1'b1;
        repeat (30) @(negedge clk);
        total++; if (evq.size() !== expq.size()) begin bad++; $display("FAIL rnd_events: got %0d want %0d", evq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
            total++;
            if (evq[i].kind * 2 + evq[i].val !== expq[i].kind * 2 + expq[i].val) begin
                bad++; $display("FAIL rnd_ev[%0d]: got kind=%0d val=%0d want kind=%0d val=%0d", i, evq[i].kind, evq[i].val, expq[i].kind, expq[i].val);
            end
        end
        spc_err = 0;
        lat_err = 0;
        k = 0;
        for (int i = 0; i < evq.size(); i++) begin
            if (evq[i].kind == K_START) begin
                if (k < fall_q.size() && (evq[i].cyc - fall_q[k] < CPB / 2 || evq[i].cyc - fall_q[k] > CPB / 2 + 4)) lat_err++;
                k++;
            end else if (i > 0 && evq[i].cyc - evq[i-1].cyc != CPB) begin
                spc_err++;
            end
        end
        total++; if (spc_err !== 0) begin bad++; $display("FAIL rnd_spacing: got %0d bad gaps want 0", spc_err); end
        total++; if (lat_err !== 0) begin bad++; $display("FAIL rnd_start_latency: got %0d bad starts want 0", lat_err); end
        total++; if (shreg !== b) begin bad++; $display("FAIL rnd_shreg: got %h want %h", shreg, b); end
        total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL pulse_overlap: got %0d cycles want 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_byte_a5();
        test_glitch();
        test_stop_err();
        rx = 1'b1;
        repeat (10) @(negedge clk);
        test_back_to_back();
        test_reset_mid();
        test_reset_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
